// File: rtl/fixed_leaky_relu_arbiter.sv
// Round-robin, tensor-granular sharing of one registered fixed-point LeakyReLU
// lane among NUM_REQ activation streams; each output beat carries id and last.
module fixed_leaky_relu_arbiter #(
  parameter int NUM_REQ                     = 4,
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int BEATS_PER_TENSOR            = 8,
  parameter int ID_WIDTH                    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]     req_data_in [NUM_REQ*DATA_IN_0_PARALLELISM_DIM_0],
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [DATA_IN_0_PRECISION_0-1:0]     cfg_slope [NUM_REQ],
  output logic [DATA_IN_0_PRECISION_0-1:0]     data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic                                 data_out_0_valid,
  input  logic                                 data_out_0_ready,
  output logic [ID_WIDTH-1:0]                  data_out_0_id,
  output logic                                 data_out_0_last
);

  localparam int W     = DATA_IN_0_PRECISION_0;
  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int PW    = 2 * W + 1;
  localparam int CNT_W = (BEATS_PER_TENSOR > 1) ? $clog2(BEATS_PER_TENSOR) : 1;
  localparam int SEL_W = $clog2(NUM_REQ * P);

  // The binary point only labels the format; input and output share it, so
  // the datapath never depends on it beyond this range guard.
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_frac_out_of_range
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg, state_next;
  logic [ID_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ID_WIDTH-1:0] gnt_reg, gnt_next;
  logic [W-1:0]        slope_reg, slope_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic                out_valid_reg, out_valid_next;
  logic                out_last_reg, out_last_next;
  logic [ID_WIDTH-1:0] out_id_reg, out_id_next;
  logic [W-1:0]        out_data_reg [P];
  logic [W-1:0]        out_data_next [P];
  logic [W-1:0]        act [P];

  logic [ID_WIDTH-1:0] winner;
  logic                any_valid;
  logic                stage_ready;
  logic                take;
  logic                last_beat;
  int                  arb_idx;

  // Scan from the farthest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    arb_idx   = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      arb_idx = (int'(ptr_reg) + off) % NUM_REQ;
      if (req_valid[ID_WIDTH'(arb_idx)]) begin
        winner    = ID_WIDTH'(arb_idx);
        any_valid = 1'b1;
      end
    end
  end

  assign stage_ready = !out_valid_reg || data_out_0_ready;
  assign take        = (state_reg == BUSY) && req_valid[gnt_reg] && stage_ready;
  assign last_beat   = (beat_cnt_reg == CNT_W'(BEATS_PER_TENSOR - 1));

  always_comb begin
    req_ready = '0;
    if (state_reg == BUSY) begin
      req_ready[gnt_reg] = stage_ready;
    end
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [SEL_W-1:0]     sel;
    logic signed [W-1:0]  x;
    logic signed [PW-1:0] prod;
    assign sel  = SEL_W'(int'(gnt_reg) * P + gi);
    assign x    = $signed(req_data_in[sel]);
    // Slope is a pure fraction, so the floored product never exceeds |x|.
    assign prod = PW'(x) * PW'($signed({1'b0, slope_reg}));
    assign act[gi] = x[W-1] ? W'(prod >>> W) : x;
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    slope_next     = slope_reg;
    beat_cnt_next  = beat_cnt_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    out_id_next    = out_id_reg;
    out_data_next  = out_data_reg;

    if (out_valid_reg && data_out_0_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          gnt_next      = winner;
          slope_next    = cfg_slope[winner];
          beat_cnt_next = '0;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (take) begin
          out_valid_next = 1'b1;
          out_data_next  = act;
          out_id_next    = gnt_reg;
          out_last_next  = last_beat;
          beat_cnt_next  = beat_cnt_reg + CNT_W'(1);
          if (last_beat) begin
            ptr_next      = gnt_reg;
            beat_cnt_next = '0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= ID_WIDTH'(NUM_REQ - 1);
      gnt_reg       <= '0;
      slope_reg     <= '0;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_id_reg    <= '0;
      for (int i = 0; i < P; i++) begin
        out_data_reg[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      slope_reg     <= slope_next;
      beat_cnt_reg  <= beat_cnt_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      out_id_reg    <= out_id_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign data_out_0       = out_data_reg;
  assign data_out_0_valid = out_valid_reg;
  assign data_out_0_id    = out_id_reg;
  assign data_out_0_last  = out_last_reg;

endmodule

// File: tb/tb_fixed_leaky_relu_arbiter.sv
// Directed bench for fixed_leaky_relu_arbiter: per-requester stimulus queues
// feed a scoreboard of expected output beats checked at the falling edge.
module tb_fixed_leaky_relu_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int P   = 1;
  localparam int B   = 8;
  localparam int IDW = 2;

  localparam byte AX [8] = '{-64, 37, -1, -128, 0, 127, -2, 5};
  localparam byte AY [8] = '{-32, 37, -1, -64, 0, 127, -1, 5};
  localparam byte BX [8] = '{-3, -128, 10, -10, 0, -1, 100, -64};
  localparam byte BY [8] = '{-1, -13, 10, -1, 0, -1, 100, -7};
  localparam byte CX [8] = '{-100, 50, -1, -128, 1, -5, 127, 0};
  localparam byte CY [8] = '{0, 50, 0, 0, 1, 0, 127, 0};

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   req_data_in [N*P];
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   cfg_slope [N];
  logic [W-1:0]   data_out_0 [P];
  logic           data_out_0_valid;
  logic           data_out_0_ready;
  logic [IDW-1:0] data_out_0_id;
  logic           data_out_0_last;

  fixed_leaky_relu_arbiter #(
    .NUM_REQ(N), .DATA_IN_0_PRECISION_0(W), .DATA_IN_0_PRECISION_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(P), .BEATS_PER_TENSOR(B), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst), .req_data_in(req_data_in), .req_valid(req_valid),
    .req_ready(req_ready), .cfg_slope(cfg_slope), .data_out_0(data_out_0),
    .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready),
    .data_out_0_id(data_out_0_id), .data_out_0_last(data_out_0_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]     d;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] in_x [N][$];
  logic [7:0] in_y [N][$];
  beat_t      sb [$];
  int         grant_q [$];
  int         n_acc [N];
  logic [N-1:0] acc = '0;
  int         cyc = 0;
  int         tcnt = 0;
  int         cur_req = -1;
  int         last_start = -1;
  bit         gap_chk = 1'b0;
  bit         bp_toggle = 1'b0;
  bit         prev_stall = 1'b0;
  beat_t      prev_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] leaky(input logic [7:0] x, input logic [7:0] s);
    int p;
    if (!x[7]) return x;
    p = int'($signed(x)) * int'(s);
    p = p >>> 8;
    return p[7:0];
  endfunction

  task automatic push_beat(input int r, input logic [7:0] x, input logic [7:0] y);
    in_x[r].push_back(x);
    in_y[r].push_back(y);
  endtask

  task automatic load_rand(input int r, input logic [7:0] s, input bit neg);
    logic [7:0] x;
    for (int i = 0; i < B; i++) begin
      x = neg ? 8'(-int'($urandom_range(128, 5))) : 8'($urandom);
      push_beat(r, x, leaky(x, s));
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < N; r++) s += in_x[r].size();
    return s;
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_valid[r]   = (in_x[r].size() > 0);
      req_data_in[r] = (in_x[r].size() > 0) ? in_x[r][0] : 8'($urandom);
    end
    data_out_0_ready = bp_toggle ? ~data_out_0_ready : 1'b1;
  endtask

  task automatic clear_model();
    sb.delete();
    grant_q.delete();
    for (int r = 0; r < N; r++) begin
      in_x[r].delete();
      in_y[r].delete();
    end
    tcnt = 0; cur_req = -1; last_start = -1; prev_stall = 1'b0; acc = '0;
  endtask

  // Called at the falling edge: check outputs, then record input handshakes.
  task automatic sample();
    beat_t cur, exp;
    cyc++;
    cur = '{data_out_0[0], data_out_0_id, data_out_0_last};
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (data_out_0_valid && !data_out_0_ready) chk("bp_ready_low", 32'(req_ready), 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(data_out_0_valid), 32'd1);
      chk("hold_beat", 32'(cur), 32'(prev_beat));
    end
    prev_stall = data_out_0_valid && !data_out_0_ready;
    prev_beat  = cur;
    if (data_out_0_valid && data_out_0_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        exp = sb.pop_front();
        $display("beat id=%0d data=%0d last=%0d (exp id=%0d data=%0d last=%0d)",
                 cur.id, $signed(cur.d), cur.last, exp.id, $signed(exp.d), exp.last);
        chk("out_data", 32'(cur.d), 32'(exp.d));
        chk("out_id", 32'(cur.id), 32'(exp.id));
        chk("out_last", 32'(cur.last), 32'(exp.last));
      end
    end
    acc = req_valid & req_ready;
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        n_acc[r]++;
        if (tcnt == 0) begin
          if (grant_q.size() > 0) chk("grant_order", 32'(r), 32'(grant_q.pop_front()));
          if (gap_chk && last_start >= 0) chk("tensor_cycles", 32'(cyc - last_start), 32'(B + 1));
          last_start = cyc;
          cur_req = r;
        end else begin
          chk("same_owner", 32'(r), 32'(cur_req));
        end
        sb.push_back('{in_y[r][0], IDW'(r), (tcnt == B - 1)});
        tcnt = (tcnt == B - 1) ? 0 : tcnt + 1;
      end
    end
  endtask

  task automatic advance();
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        void'(in_x[r].pop_front());
        void'(in_y[r].pop_front());
      end
    end
    acc = '0;
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while ((sb.size() > 0 || pending() > 0) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 300), 32'd0);
    chk({tag, "_grants_left"}, 32'(grant_q.size()), 32'd0);
  endtask

  task automatic wait_accepts(input int r, input int target);
    int n = 0;
    while (n_acc[r] < target && n < 100) begin
      step();
      n++;
    end
    chk("wait_accepts_timeout", 32'(n >= 100), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(data_out_0_valid), 32'd0);
    chk({tag, "_data"}, 32'(data_out_0[0]), 32'd0);
    chk({tag, "_id"}, 32'(data_out_0_id), 32'd0);
    chk({tag, "_last"}, 32'(data_out_0_last), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b0;
    req_valid = '0;
    data_out_0_ready = 1'b0;
    for (int r = 0; r < N; r++) begin
      req_data_in[r] = '0;
      cfg_slope[r] = '0;
    end

    // Reset held with random inputs: all outputs stay zero.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      data_out_0_ready = 1'($urandom);
      for (int r = 0; r < N; r++) begin
        req_data_in[r] = 8'($urandom);
        cfg_slope[r] = 8'($urandom);
      end
      @(negedge clk);
      check_zero("rst_hold");
    end

    // Arithmetic on requester 0 (slope 0x80); ready rises one cycle after release.
    @(posedge clk); #1;
    cfg_slope[0] = 8'h80; cfg_slope[1] = 8'h19; cfg_slope[2] = 8'h00; cfg_slope[3] = 8'h80;
    for (int i = 0; i < B; i++) push_beat(0, 8'(AX[i]), 8'(AY[i]));
    grant_q.push_back(0);
    rst = 1'b1;
    drive();
    @(negedge clk);
    chk("ready_before_grant", 32'(req_ready), 32'd0);
    sample();
    @(posedge clk); #1;
    advance();
    @(negedge clk);
    chk("ready_after_grant", 32'(req_ready), 32'h1);
    sample();
    @(posedge clk); #1;
    advance();
    run_until_idle("arith_s80");

    // Small slope and zero slope on requesters 1 and 2.
    for (int i = 0; i < B; i++) push_beat(1, 8'(BX[i]), 8'(BY[i]));
    for (int i = 0; i < B; i++) push_beat(2, 8'(CX[i]), 8'(CY[i]));
    grant_q.push_back(1); grant_q.push_back(2);
    drive();
    run_until_idle("arith_s19_s00");

    // Round-robin from a fresh reset with every requester valid.
    rst = 1'b0; clear_model(); @(posedge clk); #1; rst = 1'b1;
    cfg_slope[0] = 8'h80; cfg_slope[1] = 8'h40; cfg_slope[2] = 8'hC0; cfg_slope[3] = 8'h01;
    load_rand(0, 8'h80, 1'b0); load_rand(1, 8'h40, 1'b0);
    load_rand(2, 8'hC0, 1'b0); load_rand(3, 8'h01, 1'b0);
    load_rand(0, 8'h80, 1'b0);
    foreach (grant_q[i]) grant_q.delete(i);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    gap_chk = 1'b1;
    drive();
    run_until_idle("round_robin");
    gap_chk = 1'b0;

    // Backpressure: downstream ready toggles every cycle.
    bp_toggle = 1'b1;
    load_rand(1, 8'h40, 1'b1); load_rand(3, 8'h01, 1'b0);
    grant_q.push_back(1); grant_q.push_back(3);
    drive();
    run_until_idle("backpressure");
    bp_toggle = 1'b0;

    // Slope change at beat 3 only takes effect at the next grant.
    cfg_slope[2] = 8'h80;
    load_rand(2, 8'h80, 1'b1);
    load_rand(2, 8'h40, 1'b1);
    grant_q.push_back(2); grant_q.push_back(2);
    drive();
    base = n_acc[2];
    wait_accepts(2, base + 3);
    cfg_slope[2] = 8'h40;
    run_until_idle("slope_change");

    // Asynchronous reset after beat 4 of requester 2.
    load_rand(2, 8'h40, 1'b0);
    grant_q.push_back(2);
    drive();
    base = n_acc[2];
    wait_accepts(2, base + 4);
    chk("pre_reset_valid", 32'(data_out_0_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    clear_model();
    @(posedge clk); #1;
    load_rand(0, 8'h80, 1'b0);
    load_rand(2, 8'h40, 1'b0);
    grant_q.push_back(0); grant_q.push_back(2);
    rst = 1'b1;
    drive();
    run_until_idle("after_mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_leaky_relu_arbiter.md
# fixed_leaky_relu_arbiter

Shares one registered fixed-point LeakyReLU lane between `NUM_REQ` independent activation streams. Arbitration is round-robin at tensor granularity: once granted, a requester owns the lane for exactly `BEATS_PER_TENSOR` beats. Each requester supplies its own fixed-point negative slope. The block sits between several upstream layer outputs and one downstream consumer, and tags every output beat with its source id and a last flag.

## Interface

**Parameters**

- `NUM_REQ`, 4 — number of requesting streams (≥2).
- `DATA_IN_0_PRECISION_0`, 8 — data width W. Signed two's complement, input and output.
- `DATA_IN_0_PRECISION_1`, 1 — fractional bits. Informational only; input and output formats are identical.
- `DATA_IN_0_PARALLELISM_DIM_0`, 1 — elements per beat, P.
- `BEATS_PER_TENSOR`, 8 — beats per grant (≥1).
- `ID_WIDTH`, `max(1,$clog2(NUM_REQ))` — width of the id tag.

**Ports**

- `clk` in 1 — clock.
- `rst` in 1 — asynchronous, active-low reset.
- `req_data_in` in W × [NUM_REQ*P] — element k of requester r is at index r*P+k.
- `req_valid` in NUM_REQ — per-requester valid.
- `req_ready` out NUM_REQ — per-requester ready; at most one bit high.
- `cfg_slope` in W × [NUM_REQ] — per-requester unsigned slope, W fractional bits (range 0 to 1−2^-W).
- `data_out_0` out W × [P] — activated data.
- `data_out_0_valid` out 1 — output valid.
- `data_out_0_ready` in 1 — downstream ready.
- `data_out_0_id` out ID_WIDTH — source requester of the current beat.
- `data_out_0_last` out 1 — final beat of a tensor.

## Operation

**State machine:** two states, IDLE and BUSY.

**IDLE**
- `req_ready` = 0.
- If any `req_valid` is high, grant the first valid requester searching from `ptr+1` upward, with wrap-around.
- On grant, latch: `gnt` ← winner, slope register ← `cfg_slope[winner]`, `beat_cnt` ← 0. Next state is BUSY.
- No valid requesters: stay in IDLE.

**BUSY**
- `req_ready[gnt]` = `stage_ready`, where `stage_ready` = `!data_out_0_valid || data_out_0_ready`. All other ready bits are 0.
- A handshake on `gnt` loads the output register with the activated data, `id` = `gnt`, and `last` = (`beat_cnt == BEATS_PER_TENSOR-1`). It then increments `beat_cnt`.
- The handshake with `last` set also does `ptr` ← `gnt` and returns to IDLE.
- Non-granted requesters are never consumed; their valid/data may change freely.

**Slope:** `cfg_slope` is sampled only at grant. Changes during BUSY have no effect until the next grant.

**Arithmetic, per element x**
- x ≥ 0: output x, unchanged.
- x < 0: prod = x × signed{1'b0, slope}, computed at 2W+1 bits.
  - Output = (prod >>> W), truncated to W bits.
  - The arithmetic shift floors toward −∞. No rounding, no saturation (the magnitude cannot grow).

**Output register:**
- Holds its value while `data_out_0_valid && !data_out_0_ready`.
- Clears `valid` on a downstream handshake that has no new load in the same cycle.
- Simultaneous load and drain: the new beat replaces the old one, and `valid` stays 1.

**Reset (`rst`=0, any time, including mid-tensor)**
- State ← IDLE.
- `ptr` ← NUM_REQ-1, so requester 0 has first priority.
- `beat_cnt`, `gnt`, slope register ← 0.
- `data_out_0_valid`, `data_out_0`, `data_out_0_id`, `data_out_0_last` ← 0; `req_ready` ← 0.
- A partially transferred tensor is abandoned. After release, arbitration restarts from requester 0.

## Timing

- Arbitration: 1 cycle in IDLE per tensor. `req_ready` can first rise on the cycle after the grant decision.
- Data latency: input handshake at cycle t gives `data_out_0_valid` at t+1.
- Throughput: 1 beat/cycle within a tensor under no backpressure. One bubble cycle between tensors, so BEATS_PER_TENSOR beats take BEATS_PER_TENSOR+1 cycles.
- Backpressure: when `data_out_0_ready`=0 and the output register is full, `req_ready[gnt]`=0 in the same cycle (combinational path from `data_out_0_ready`).
- All outputs are registered except `req_ready`, which is decoded from state, `gnt` and `stage_ready`.

## Test plan

- **Reset:** hold `rst`=0 with random inputs → every output is 0. Release, assert `req_valid`=0b0001 → `req_ready[0]` rises 1 cycle later.
- **Arithmetic:** W=8, P=1, slope=0x80.
  - x = −64, 37, −1, −128 → out −32, 37, −1, −64.
  - slope=0x19, x=−3 → −1. slope=0, x=−100 → 0.
- **Round-robin:** all four `req_valid` held high, BEATS_PER_TENSOR=8 → grants in order 0,1,2,3,0.
  - Each tensor is 8 beats; `last` is set on beat 8 only; `id` matches the grant.
  - 9 cycles per tensor.
- **Backpressure:** toggle `data_out_0_ready` every cycle → no beat lost or duplicated. Output is held stable while stalled. `req_ready` is 0 whenever the register is full and `data_out_0_ready`=0.
- **Slope change mid-tensor:** change `cfg_slope[gnt]` from 0x80 to 0x40 at beat 3 → all 8 beats use 0x80. The next grant of that requester uses 0x40.
- **Reset mid-tensor:** assert `rst` after beat 4 of requester 2 → outputs are 0 immediately. After release, requester 0 (if valid) is granted first, and beat counting restarts at 0.
